// File: rtl/nixie_time_bcd.sv
// Time-of-day keeper for the nixie serializer.
// Keeps HH:MM:SS in BCD and advances it on each GPS PPS rising edge.
// If PPS disappears, it free-runs from the local clock (holdover).
// The host can load an absolute time; the load is applied on the next second tick.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   pps        raw GPS PPS, asynchronous to clk
//   load_valid host time load request
//   load_time  BCD {H1,H0,M1,M0,S1,S0}
//   load_ready high while no load is pending
//   load_err   1-cycle pulse when a load is rejected
//   NixieBCD   {H1,H0,F,M1,M0,F,S1,S0}; 4'hF blanks a tube
//   digitpoint point mask for the serializer
//   tick       1-cycle pulse per second advance
//   pps_lost   high while in holdover
module nixie_time_bcd #(
  parameter int unsigned CLK_HZ      = 10_000_000,
  parameter int unsigned PPS_TIMEOUT = CLK_HZ + CLK_HZ / 16,
  parameter logic [15:0] DP_PATTERN  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pps,
  input  logic        load_valid,
  input  logic [23:0] load_time,
  output logic        load_ready,
  output logic        load_err,
  output logic [31:0] NixieBCD,
  output logic [15:0] digitpoint,
  output logic        tick,
  output logic        pps_lost
);

  localparam int unsigned CntW = $clog2(PPS_TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(PPS_TIMEOUT - 1);
  localparam logic [CntW-1:0] SecondLast  = CntW'(CLK_HZ - 1);

  typedef enum logic [0:0] {StSynced, StHoldover} state_e;

  state_e            state_q, state_d;
  logic              pps_meta_q, pps_sync_q, pps_prev_q;
  logic [CntW-1:0]   cnt_q;
  logic [23:0]       time_q, time_next;
  logic              pend_q;
  logic [23:0]       pend_time_q;
  logic              tick_q, tick_d;
  logic              load_err_q;
  logic [15:0]       dp_q, dp_next;
  logic              pps_rise;
  logic              accept;
  logic              load_ok;

  // One-second BCD increment with a 23:59:59 -> 00:00:00 wrap.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd9) begin
      s0 = s0 + 4'd1;
    end else begin
      s0 = 4'd0;
      if (s1 != 4'd5) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (m0 != 4'd9) begin
          m0 = m0 + 4'd1;
        end else begin
          m0 = 4'd0;
          if (m1 != 4'd5) begin
            m1 = m1 + 4'd1;
          end else begin
            m1 = 4'd0;
            if (h1 == 4'd2 && h0 == 4'd3) begin
              h1 = 4'd0;
              h0 = 4'd0;
            end else if (h0 != 4'd9) begin
              h0 = h0 + 4'd1;
            end else begin
              h0 = 4'd0;
              h1 = h1 + 4'd1;
            end
          end
        end
      end
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  function automatic logic time_valid(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       digits_ok;
    {h1, h0, m1, m0, s1, s0} = t;
    digits_ok = (h1 <= 4'd9) && (h0 <= 4'd9) && (m0 <= 4'd9) && (s0 <= 4'd9);
    return digits_ok && (m1 <= 4'd5) && (s1 <= 4'd5) &&
           ((h1 < 4'd2) || (h1 == 4'd2 && h0 <= 4'd3));
  endfunction

  assign pps_rise = pps_sync_q & ~pps_prev_q;
  assign accept   = load_valid & ~pend_q;
  assign load_ok  = time_valid(load_time);

  always_comb begin
    tick_d  = 1'b0;
    state_d = state_q;
    unique case (state_q)
      StSynced: begin
        if (pps_rise) begin
          tick_d = 1'b1;
        end else if (cnt_q == TimeoutLast) begin
          tick_d  = 1'b1;
          state_d = StHoldover;
        end
      end
      StHoldover: begin
        // An edge and the terminal count together still give a single tick.
        if (pps_rise) begin
          tick_d  = 1'b1;
          state_d = StSynced;
        end else if (cnt_q == SecondLast) begin
          tick_d = 1'b1;
        end
      end
      default: state_d = StSynced;
    endcase
  end

  // A pending load replaces the increment; a load accepted in this cycle is not yet pending.
  assign time_next = pend_q ? pend_time_q : bcd_inc(time_q);

  // Points blink with even seconds when synced; steady in holdover to flag lost lock.
  assign dp_next = ((state_d == StHoldover) || !time_next[0]) ? DP_PATTERN : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StSynced;
      pps_meta_q  <= 1'b0;
      pps_sync_q  <= 1'b0;
      pps_prev_q  <= 1'b0;
      cnt_q       <= '0;
      time_q      <= 24'h000000;
      pend_q      <= 1'b0;
      pend_time_q <= 24'h000000;
      tick_q      <= 1'b0;
      load_err_q  <= 1'b0;
      dp_q        <= DP_PATTERN;
    end else begin
      pps_meta_q <= pps;
      pps_sync_q <= pps_meta_q;
      pps_prev_q <= pps_sync_q;
      state_q    <= state_d;
      tick_q     <= tick_d;
      cnt_q      <= tick_d ? '0 : cnt_q + CntW'(1);
      load_err_q <= accept & ~load_ok;
      if (tick_d) begin
        time_q <= time_next;
        dp_q   <= dp_next;
      end
      if (accept && load_ok) begin
        pend_q      <= 1'b1;
        pend_time_q <= load_time;
      end else if (tick_d) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign load_ready = ~pend_q;
  assign load_err   = load_err_q;
  assign NixieBCD   = {time_q[23:16], 4'hF, time_q[15:8], 4'hF, time_q[7:0]};
  assign digitpoint = dp_q;
  assign tick       = tick_q;
  assign pps_lost   = (state_q == StHoldover);

endmodule

// File: tb/tb_nixie_time_bcd.sv
module tb_nixie_time_bcd;

  localparam int unsigned CLK_HZ      = 100;
  localparam int unsigned PPS_TIMEOUT = 106;
  localparam logic [15:0] DP          = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        pps;
  logic        load_valid;
  logic [23:0] load_time;
  logic        load_ready;
  logic        load_err;
  logic [31:0] NixieBCD;
  logic [15:0] digitpoint;
  logic        tick;
  logic        pps_lost;

  nixie_time_bcd #(
    .CLK_HZ     (CLK_HZ),
    .PPS_TIMEOUT(PPS_TIMEOUT),
    .DP_PATTERN (DP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pps       (pps),
    .load_valid(load_valid),
    .load_time (load_time),
    .load_ready(load_ready),
    .load_err  (load_err),
    .NixieBCD  (NixieBCD),
    .digitpoint(digitpoint),
    .tick      (tick),
    .pps_lost  (pps_lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds of the day.
  int m_secs;
  bit m_pend;
  int m_pend_secs;
  bit m_hold;

  function automatic logic [31:0] to_nixie(input int s);
    int h, m, ss;
    h  = s / 3600;
    m  = (s / 60) % 60;
    ss = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'hF, 4'(m / 10), 4'(m % 10), 4'hF,
            4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] dp_exp();
    if (m_hold) return DP;
    return (m_secs % 2 == 0) ? DP : 16'h0000;
  endfunction

  function automatic bit load_is_valid(input logic [23:0] v);
    int d[6];
    for (int k = 0; k < 6; k++) d[k] = int'(v[4*k +: 4]);
    for (int k = 0; k < 6; k++) if (d[k] > 9) return 1'b0;
    if (d[1] > 5 || d[3] > 5) return 1'b0;
    return (d[5] * 10 + d[4]) <= 23;
  endfunction

  function automatic int bcd_to_secs(input logic [23:0] v);
    return (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
           (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
           int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_secs = 0;
    m_pend = 1'b0;
    m_pend_secs = 0;
    m_hold = 1'b0;
  endtask

  task automatic model_tick();
    if (m_pend) begin
      m_secs = m_pend_secs;
      m_pend = 1'b0;
    end else begin
      m_secs = (m_secs + 1) % 86400;
    end
  endtask

  task automatic check_time(input string tag);
    check({tag, "_bcd"}, NixieBCD, to_nixie(m_secs));
    check({tag, "_dp"}, digitpoint, {16'h0, dp_exp()});
    check({tag, "_lost"}, pps_lost, 32'(m_hold));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bcd"}, NixieBCD, 32'h00F00F00);
    check({tag, "_dp"}, digitpoint, {16'h0, DP});
    check({tag, "_tick"}, tick, 0);
    check({tag, "_lost"}, pps_lost, 0);
    check({tag, "_ready"}, load_ready, 1);
    check({tag, "_err"}, load_err, 0);
  endtask

  task automatic wait_tick(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (tick) begin
        lat = i;
        break;
      end
    end
  endtask

  // Raise PPS, expect a tick 3 cycles later, then drop PPS; ends 4 cycles after the tick.
  task automatic pps_edge(input string tag);
    int lat;
    pps = 1'b1;
    wait_tick(8, lat);
    check({tag, "_lat"}, 32'(lat), 3);
    if (lat > 0) begin
      m_hold = 1'b0;
      model_tick();
    end
    check_time(tag);
    step();
    check({tag, "_pulse"}, tick, 0);
    step();
    step();
    pps = 1'b0;
    step();
  endtask

  // Holdover tick after a bounded wait with expected spacing.
  task automatic hold_tick(input string tag, input int exp_lat);
    int lat;
    wait_tick(exp_lat + 20, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (lat > 0) begin
      m_hold = 1'b1;
      model_tick();
    end
    check_time(tag);
  endtask

  task automatic do_load(input string tag, input logic [23:0] v);
    bit ok;
    ok = load_is_valid(v);
    check({tag, "_rdy_before"}, load_ready, 1);
    load_valid = 1'b1;
    load_time  = v;
    step();
    load_valid = 1'b0;
    if (ok) begin
      m_pend = 1'b1;
      m_pend_secs = bcd_to_secs(v);
    end
    check({tag, "_ready"}, load_ready, 32'(!ok));
    check({tag, "_err"}, load_err, 32'(!ok));
    step();
    check({tag, "_err_pulse"}, load_err, 0);
    check({tag, "_time_kept"}, NixieBCD, to_nixie(m_secs));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nix;
    logic [23:0] v;
    rst = 1'b1;
    pps = 1'b0;
    load_valid = 1'b0;
    load_time = 24'h0;
    model_reset();
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) step();

    pps_edge("first");

    do_load("ld235958", 24'h235958);
    repeat (5) step();
    pps_edge("apply235958");
    pps_edge("t235959");
    pps_edge("wrap");

    do_load("bad245900", 24'h245900);
    do_load("bad006000", 24'h006000);
    pps_edge("after_bad");

    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        nix = to_nixie(int'($urandom_range(0, 86399)));
        v = {nix[31:24], nix[19:12], nix[7:0]};
      end else begin
        v = 24'($urandom());
      end
      do_load("rnd_load", v);
      repeat ($urandom_range(1, 20)) step();
      pps_edge("rnd_tick");
    end

    // Load accepted in the same cycle as a tick waits for the following tick.
    repeat (5) step();
    pps = 1'b1;
    step();
    step();
    load_valid = 1'b1;
    load_time = 24'h120000;
    step();
    load_valid = 1'b0;
    check("samecyc_tick", tick, 1);
    model_tick();
    m_pend = 1'b1;
    m_pend_secs = 12 * 3600;
    check_time("samecyc");
    check("samecyc_ready", load_ready, 0);
    step();
    pps = 1'b0;
    repeat (5) step();
    pps_edge("samecyc_apply");

    // PPS stops: pps_edge ends 4 cycles after its tick, so timeout lands 102 cycles later.
    hold_tick("hold_enter", 102);
    hold_tick("hold_1", 100);
    hold_tick("hold_2", 100);
    repeat (40) step();
    pps_edge("restore");

    // Edge detected in the same cycle as the holdover terminal count.
    hold_tick("hold_enter2", 102);
    repeat (97) step();
    pps_edge("coincide");

    // Reset mid-holdover with a pending load.
    hold_tick("hold_enter3", 102);
    do_load("ld_before_rst", 24'h101010);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    step();
    rst = 1'b0;
    repeat (3) step();
    pps_edge("post_rst");
    check("post_rst_ready", load_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nixie_time_bcd.md
Name: nixie_time_bcd

Overview:
- Upstream stage of the nixie serializer: keeps local time-of-day (HH:MM:SS) in BCD.
- Advances it on each GPS PPS rising edge and presents it as the 8-digit NixieBCD word plus the digitpoint mask.
- Host (Raspberry Pi) loads absolute time through a valid/ready port; the load takes effect on the next second tick.
- Free-runs from the local clock if PPS disappears (holdover).

Parameters:
- CLK_HZ, 10_000_000, clk frequency; nominal cycles per second in holdover.
- PPS_TIMEOUT, CLK_HZ + CLK_HZ/16, cycles without a PPS edge before entering holdover.
- DP_PATTERN, 16'h0000, digitpoint mask shown on even seconds.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pps  in  1  raw GPS PPS, asynchronous to clk
- load_valid  in  1  host time load request
- load_time  in  24  BCD {H1,H0,M1,M0,S1,S0}, 4 bits each, H1 at [23:20]
- load_ready  out  1  high when no load is pending
- load_err  out  1  1-cycle pulse: load rejected
- NixieBCD  out  32  {H1,H0,F,M1,M0,F,S1,S0}; 4'hF = blank tube
- digitpoint  out  16  point mask to serializer
- tick  out  1  1-cycle pulse per second advance
- pps_lost  out  1  high while in holdover

Behaviour:
- Reset (async assert, sync release): time 00:00:00, so NixieBCD = 32'h00F00F00, digitpoint = DP_PATTERN, tick = 0, pps_lost = 0, load_ready = 1, load_err = 0, state SYNCED, cycle counter 0, no pending load.
- PPS path: 2-flop synchronizer, then a third register for rising-edge detect.
  - tick and the updated NixieBCD appear together, registered, on the 3rd clk rising edge after pps rises.
  - The serializer latches on PPS falling edge, so the data is stable by then.
- Cycle counter: cleared on every tick, otherwise +1; width ceil(log2(PPS_TIMEOUT+1)).
- States:
  - SYNCED: tick only on a PPS rising edge. If the counter reaches PPS_TIMEOUT-1 with no edge, go to HOLDOVER, set pps_lost, issue a tick that same cycle, clear the counter.
  - HOLDOVER: internal tick whenever the counter reaches CLK_HZ-1. A PPS rising edge ticks immediately, clears the counter and pps_lost, and returns to SYNCED. Edge and internal terminal count in the same cycle produce exactly one tick.
- On tick, if a load is pending: time := pending value, pending cleared, load_ready := 1.
- On tick, otherwise: BCD increment with cascade S0 9→0 carries S1; S1 5→0 carries M0; M0 and M1 likewise; H0 9→0 carries H1; 23:59:59 → 00:00:00.
- Load handshake:
  - Accept when load_valid && load_ready.
  - Validation: every digit ≤ 9, S1 ≤ 5, M1 ≤ 5, H1H0 ≤ 23.
  - Valid load: store as pending, load_ready := 0 from the next cycle.
  - Invalid load: load_err pulses 1 cycle, nothing stored, load_ready stays 1.
  - A load accepted in the same cycle as a tick is not applied by that tick; it is applied at the following tick.
  - load_valid while load_ready = 0 is ignored.
- digitpoint:
  - SYNCED: DP_PATTERN when S0 is even, 16'h0000 when odd; updated with NixieBCD.
  - HOLDOVER: steady DP_PATTERN (no blink).
- Reset asserted mid-operation: all state returns to reset values immediately and a pending load is discarded.
- NixieBCD changes only in a tick cycle (or on reset).

Test Plan:
- Reset, then one pps pulse → tick exactly 3 clk after pps rise; NixieBCD = 32'h00F00F01; digitpoint = 0 (odd second).
- Load 24'h235958 between PPS edges → load_ready drops. Next PPS: NixieBCD = 32'h23F59F58. Next PPS: 32'h00F00F00 after the intermediate 23:59:59 tick, i.e. the sequence 235958 → 235959 → 000000.
- Load 24'h245900, then 24'h006000 → load_err pulses once per load, load_ready stays 1, time unchanged.
- CLK_HZ = 100, PPS_TIMEOUT = 106; stop pps after a tick → pps_lost and tick at cycle 106, then ticks every 100 cycles. Restore pps → tick at the edge+3, pps_lost = 0.
- load_valid asserted in the same cycle as a tick → that tick increments normally; the loaded value appears at the following tick.
- Assert rst mid-holdover with a load pending → outputs return to reset values at once; next pps gives 32'h00F00F01.
